// File: rtl/ofm_pack_pkg.sv
// rtl/ofm_pack_pkg.sv - shared defaults, derived widths and row entry type for the ofm row packer
package ofm_pack_pkg;

    // Width needed to hold a count from 0 to n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    localparam int DATA_WIDTH_D    = 16;
    localparam int ROW_WORDS_D     = 8;
    localparam int FIFO_DEPTH_D    = 4;
    localparam int ROW_CNT_WIDTH_D = 16;

    localparam int WCNT_W = cnt_width(ROW_WORDS_D);
    localparam int PTR_W  = $clog2(FIFO_DEPTH_D);

    typedef struct packed {
        logic [ROW_WORDS_D*DATA_WIDTH_D-1:0] data;
        logic [ROW_CNT_WIDTH_D-1:0]          idx;
        logic [WCNT_W-1:0]                   words;
    } row_word_t;

endpackage

// File: rtl/ofm_row_packer_if.sv
// rtl/ofm_row_packer_if.sv - packed-row output handshake bundle (row_words present under OFM_PACK_FLUSH_EN)
interface ofm_row_packer_if
    import ofm_pack_pkg::*;
#(
    parameter int DATA_WIDTH    = DATA_WIDTH_D,
    parameter int ROW_WORDS     = ROW_WORDS_D,
    parameter int ROW_CNT_WIDTH = ROW_CNT_WIDTH_D
);
    logic [ROW_WORDS*DATA_WIDTH-1:0] row_data;
    logic [ROW_CNT_WIDTH-1:0]        row_idx;
    logic                            row_valid;
    logic                            row_ready;
`ifdef OFM_PACK_FLUSH_EN
    logic [cnt_width(ROW_WORDS)-1:0] row_words;

    modport master (output row_data, output row_idx, output row_valid, output row_words, input row_ready);
    modport slave  (input row_data, input row_idx, input row_valid, input row_words, output row_ready);
`else
    modport master (output row_data, output row_idx, output row_valid, input row_ready);
    modport slave  (input row_data, input row_idx, input row_valid, output row_ready);
`endif
endinterface

// File: rtl/ofm_row_packer_row_fifo.sv
// rtl/ofm_row_packer_row_fifo.sv - synchronous row FIFO with full/empty and occupancy threshold flag
module row_fifo
    import ofm_pack_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = 3
) (
    input  logic             clk1,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic             almost_full
);
    localparam int P_W   = $clog2(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [P_W-1:0]   wr_ptr;
    logic [P_W-1:0]   rd_ptr;
    logic [CNT_W-1:0] count;
    logic             pop_ok;
    logic             push_ok;

    // A pop on empty is ignored; a push on full only lands if a pop frees the slot.
    assign pop_ok      = pop && !empty;
    assign push_ok     = push && (!full || pop_ok);
    assign full        = (count == CNT_W'(DEPTH));
    assign empty       = (count == '0);
    assign almost_full = (count >= CNT_W'(AF_LEVEL));
    assign pop_data    = empty ? '0 : mem[rd_ptr];

    // Storage array; contents need no reset because the head is masked while empty.
    always_ff @(posedge clk1) begin
        if (push_ok && !clear) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop_ok)      count <= count + 1'b1;
            else if (pop_ok && !push_ok) count <= count - 1'b1;
        end
    end
endmodule

// File: rtl/ofm_row_packer.sv
// rtl/ofm_row_packer.sv - packs accelerator ofm words into rows and queues them downstream (OFM_PACK_FLUSH_EN adds partial-row flush)
module ofm_row_packer
    import ofm_pack_pkg::*;
#(
    parameter int DATA_WIDTH    = DATA_WIDTH_D,
    parameter int ROW_WORDS     = ROW_WORDS_D,
    parameter int FIFO_DEPTH    = FIFO_DEPTH_D,
    parameter int ROW_CNT_WIDTH = ROW_CNT_WIDTH_D
) (
    input  logic                  clk1,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] ofm_in,
    input  logic                  valid_in,
`ifdef OFM_PACK_FLUSH_EN
    input  logic                  flush,
`endif
    output logic                  almost_full,
    output logic                  overflow,
    ofm_row_packer_if.master      row_if
);
    localparam int WC_W   = cnt_width(ROW_WORDS);
    localparam int SLOT_W = $clog2(ROW_WORDS);
    localparam int ROW_W  = ROW_WORDS * DATA_WIDTH;
`ifdef OFM_PACK_FLUSH_EN
    localparam int ENTRY_W = ROW_W + ROW_CNT_WIDTH + WC_W;
`else
    localparam int ENTRY_W = ROW_W + ROW_CNT_WIDTH;
`endif

    logic [WC_W-1:0]                       word_cnt;
    logic [SLOT_W-1:0]                     wr_slot;
    logic [ROW_WORDS-1:0][DATA_WIDTH-1:0]  slots;
    logic [ROW_WORDS-1:0][DATA_WIDTH-1:0]  row_vec;
    logic [ROW_CNT_WIDTH-1:0]              row_cnt;
    logic                                  last_word;
    logic                                  row_push;
    logic                                  pop_ok;
    logic                                  fifo_full;
    logic                                  fifo_empty;
    logic [ENTRY_W-1:0]                    push_entry;
    logic [ENTRY_W-1:0]                    head_entry;

    assign wr_slot   = word_cnt[SLOT_W-1:0];
    assign last_word = valid_in && (word_cnt == WC_W'(ROW_WORDS - 1));
    assign pop_ok    = row_if.row_valid && row_if.row_ready;

`ifdef OFM_PACK_FLUSH_EN
    logic [WC_W-1:0] push_words;
    assign push_words = word_cnt + WC_W'(valid_in);
    // Flush on an empty assembler with no incoming word has nothing to push.
    assign row_push   = last_word || (flush && ((word_cnt != '0) || valid_in));
    assign push_entry = {row_vec, row_cnt, push_words};
    assign {row_if.row_data, row_if.row_idx, row_if.row_words} = head_entry;
`else
    assign row_push   = last_word;
    assign push_entry = {row_vec, row_cnt};
    assign {row_if.row_data, row_if.row_idx} = head_entry;
`endif

    assign row_if.row_valid = !fifo_empty;

    // Row image being pushed: held slots plus the word arriving this cycle.
    always_comb begin
        row_vec = slots;
        if (valid_in) begin
            row_vec[wr_slot] = ofm_in;
        end
    end

    // Assembly slots, word count, row sequence counter and sticky drop flag.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt <= '0;
            slots    <= '0;
            row_cnt  <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            word_cnt <= '0;
            slots    <= '0;
            row_cnt  <= '0;
            overflow <= 1'b0;
        end else begin
            if (row_push) begin
                // Slots are zeroed so a later partial row has clean unfilled words.
                word_cnt <= '0;
                slots    <= '0;
                row_cnt  <= row_cnt + 1'b1;
                if (fifo_full && !pop_ok) overflow <= 1'b1;
            end else if (valid_in) begin
                slots[wr_slot] <= ofm_in;
                word_cnt       <= word_cnt + 1'b1;
            end
        end
    end

    row_fifo #(
        .WIDTH    (ENTRY_W),
        .DEPTH    (FIFO_DEPTH),
        .AF_LEVEL (FIFO_DEPTH - 1)
    ) u_row_fifo (
        .clk1        (clk1),
        .rst_n       (rst_n),
        .clear       (clear),
        .push        (row_push),
        .push_data   (push_entry),
        .pop         (row_if.row_ready),
        .pop_data    (head_entry),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .almost_full (almost_full)
    );
endmodule

// File: tb/tb_ofm_row_packer.sv
// tb/tb_ofm_row_packer.sv - directed self-checking bench for ofm_row_packer (covers OFM_PACK_FLUSH_EN when defined)
module tb_ofm_row_packer;
    import ofm_pack_pkg::*;

    logic        clk1 = 1'b0;
    logic        rst_n;
    logic        clear;
    logic [15:0] ofm_in;
    logic        valid_in;
    logic        almost_full;
    logic        overflow;
`ifdef OFM_PACK_FLUSH_EN
    logic        flush;
`endif

    int n_checks = 0;
    int n_errors = 0;
    bit mon_en   = 1'b0;
    row_word_t q[$];

    ofm_row_packer_if row_if ();

    ofm_row_packer u_dut (
        .clk1        (clk1),
        .rst_n       (rst_n),
        .clear       (clear),
        .ofm_in      (ofm_in),
        .valid_in    (valid_in),
`ifdef OFM_PACK_FLUSH_EN
        .flush       (flush),
`endif
        .almost_full (almost_full),
        .overflow    (overflow),
        .row_if      (row_if)
    );

    always #5 clk1 = ~clk1;

    // Record every row that the next rising edge will pop.
    always @(negedge clk1) begin
        if (mon_en && row_if.row_valid && row_if.row_ready) begin
            row_word_t e;
            e.data = row_if.row_data;
            e.idx  = row_if.row_idx;
`ifdef OFM_PACK_FLUSH_EN
            e.words = row_if.row_words;
`else
            e.words = '0;
`endif
            q.push_back(e);
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_word(input int w);
        valid_in = 1'b1;
        ofm_in   = 16'(w);
        tick();
        valid_in = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 20 && row_if.row_valid; n++) tick();
        chk("drain_empty", 128'(row_if.row_valid), 128'(0));
    endtask

    function automatic logic [127:0] mkrow(input int base);
        logic [127:0] r;
        for (int k = 0; k < 8; k++) r[k*16 +: 16] = 16'(base + k);
        return r;
    endfunction

    initial begin
        logic [127:0] part;
        rst_n = 1'b0;
        clear = 1'b0;
        ofm_in = '0;
        valid_in = 1'b0;
        row_if.row_ready = 1'b0;
`ifdef OFM_PACK_FLUSH_EN
        flush = 1'b0;
`endif
        idle(2);
        chk("rst_valid", 128'(row_if.row_valid), 128'(0));
        chk("rst_data", row_if.row_data, 128'(0));
        chk("rst_idx", 128'(row_if.row_idx), 128'(0));
        chk("rst_af", 128'(almost_full), 128'(0));
        chk("rst_ovf", 128'(overflow), 128'(0));
        rst_n = 1'b1;
        idle(1);

        // Single row, consecutive words, row_valid for exactly one cycle.
        row_if.row_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            valid_in = 1'b1;
            ofm_in = 16'(i + 1);
            tick();
            if (i == 6) chk("t1_valid_early", 128'(row_if.row_valid), 128'(0));
        end
        valid_in = 1'b0;
        chk("t1_valid", 128'(row_if.row_valid), 128'(1));
        chk("t1_data", row_if.row_data, mkrow(1));
        chk("t1_idx", 128'(row_if.row_idx), 128'(0));
        tick();
        chk("t1_valid_gone", 128'(row_if.row_valid), 128'(0));

        // 40 words with gaps, five rows.
        do_clear();
        q.delete();
        mon_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            send_word(i);
            idle(1);
        end
        idle(2);
        mon_en = 1'b0;
        chk("t2_rows", 128'(q.size()), 128'(5));
        for (int k = 0; k < 5 && k < q.size(); k++) begin
            chk("t2_idx", 128'(q[k].idx), 128'(k));
            chk("t2_data", q[k].data, mkrow(8 * k));
        end
        chk("t2_ovf", 128'(overflow), 128'(0));

        // Backpressure: fill, drop two rows, drain, observe the gap.
        do_clear();
        row_if.row_ready = 1'b0;
        for (int i = 0; i < 48; i++) begin
            send_word(i);
            if (i == 15) chk("t3_af_two", 128'(almost_full), 128'(0));
            if (i == 23) chk("t3_af_three", 128'(almost_full), 128'(1));
            if (i == 31) chk("t3_ovf_full", 128'(overflow), 128'(0));
            if (i == 39) chk("t3_ovf_drop", 128'(overflow), 128'(1));
        end
        chk("t3_hold_idx", 128'(row_if.row_idx), 128'(0));
        chk("t3_hold_data", row_if.row_data, mkrow(0));
        q.delete();
        mon_en = 1'b1;
        row_if.row_ready = 1'b1;
        drain();
        chk("t3_rows", 128'(q.size()), 128'(4));
        for (int k = 0; k < 4 && k < q.size(); k++) begin
            chk("t3_idx", 128'(q[k].idx), 128'(k));
            chk("t3_data", q[k].data, mkrow(8 * k));
        end
        q.delete();
        for (int i = 0; i < 8; i++) send_word(200 + i);
        idle(2);
        chk("t3_next_rows", 128'(q.size()), 128'(1));
        if (q.size() > 0) begin
            chk("t3_next_idx", 128'(q[0].idx), 128'(6));
            chk("t3_next_data", q[0].data, mkrow(200));
        end
        chk("t3_ovf_sticky", 128'(overflow), 128'(1));
        mon_en = 1'b0;

        // Push onto a full FIFO with a simultaneous pop.
        do_clear();
        row_if.row_ready = 1'b0;
        for (int i = 0; i < 32; i++) send_word(i);
        chk("t4_af", 128'(almost_full), 128'(1));
        for (int i = 0; i < 7; i++) send_word(300 + i);
        valid_in = 1'b1;
        ofm_in = 16'(307);
        row_if.row_ready = 1'b1;
        tick();
        valid_in = 1'b0;
        row_if.row_ready = 1'b0;
        chk("t4_ovf", 128'(overflow), 128'(0));
        chk("t4_head_idx", 128'(row_if.row_idx), 128'(1));
        q.delete();
        mon_en = 1'b1;
        row_if.row_ready = 1'b1;
        drain();
        mon_en = 1'b0;
        chk("t4_rows", 128'(q.size()), 128'(4));
        if (q.size() == 4) begin
            chk("t4_first_idx", 128'(q[0].idx), 128'(1));
            chk("t4_last_idx", 128'(q[3].idx), 128'(4));
            chk("t4_last_data", q[3].data, mkrow(300));
        end

        // Clear discards a partial row.
        do_clear();
        for (int i = 0; i < 3; i++) send_word(50 + i);
        do_clear();
        q.delete();
        mon_en = 1'b1;
        for (int i = 0; i < 8; i++) send_word(100 + i);
        idle(2);
        mon_en = 1'b0;
        chk("t5_rows", 128'(q.size()), 128'(1));
        if (q.size() > 0) begin
            chk("t5_idx", 128'(q[0].idx), 128'(0));
            chk("t5_data", q[0].data, mkrow(100));
        end

`ifdef OFM_PACK_FLUSH_EN
        // Flush with nothing assembled is a no-op; then flush a 3-word row.
        do_clear();
        row_if.row_ready = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t6_noop_valid", 128'(row_if.row_valid), 128'(0));
        send_word(5);
        send_word(6);
        send_word(7);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        part = '0;
        part[15:0]  = 16'd5;
        part[31:16] = 16'd6;
        part[47:32] = 16'd7;
        chk("t6_valid", 128'(row_if.row_valid), 128'(1));
        chk("t6_data", row_if.row_data, part);
        chk("t6_words", 128'(row_if.row_words), 128'(3));
        chk("t6_idx", 128'(row_if.row_idx), 128'(0));
        q.delete();
        mon_en = 1'b1;
        row_if.row_ready = 1'b1;
        for (int i = 0; i < 8; i++) send_word(10 + i);
        idle(2);
        mon_en = 1'b0;
        chk("t6_rows", 128'(q.size()), 128'(2));
        if (q.size() == 2) begin
            chk("t6_full_idx", 128'(q[1].idx), 128'(1));
            chk("t6_full_words", 128'(q[1].words), 128'(8));
            chk("t6_full_data", q[1].data, mkrow(10));
        end
`else
        part = '0;
        chk("t6_idle_data", row_if.row_data, part);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
